operand_gather_buffer: RTL and testbench
========================================

Name: operand_gather_buffer

Overview:
- Parametrised successor to the fixed 3-channel x/w collection buffer.
- Captures one (x, w) operand pair per upstream channel, each on that channel's done pulse.
- Once every channel has reported, streams the pairs in channel order to the neuron MAC over a valid/ready handshake.
- Holds the round until the neuron signals completion, then re-arms for the next round.

Parameters:
- N_CH, 3: number of upstream channels, at least 1.
- DW, 16: operand width in bits, for both x and w.
- IW, $clog2(N_CH) with a minimum of 1: width of out_idx (derived localparam; do not override).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- done  input  N_CH  per-channel capture strobe; bit i is sampled at each rising edge.
- x_in  input  N_CH*DW  activations; channel i occupies [i*DW +: DW].
- w_in  input  N_CH*DW  weights; same packing as x_in.
- out_x  output  DW  current activation beat.
- out_w  output  DW  current weight beat.
- out_valid  output  1  beat valid.
- out_ready  input  1  MAC accepts the beat.
- out_idx  output  IW  channel index of the current beat.
- out_last  output  1  current beat is channel N_CH-1.
- neuron_done  input  1  MAC finished the accumulation; releases the round.
- fill_mask  output  N_CH  channels captured in the current round.
- busy  output  1  high when the state is not COLLECT.
- overrun  output  1  sticky flag: a done arrived while the round was locked.

Behaviour:
- Storage: N_CH x-registers, N_CH w-registers, fill_mask register, IW-bit beat counter, overrun flag, 2-bit state.
- Reset values: state COLLECT, all storage 0, fill_mask 0, counter 0, overrun 0. Outputs at reset: out_valid=0, out_x=0, out_w=0, out_idx=0, out_last=0, busy=0.
- Reset applied mid-operation (any state) aborts the round with the same result; no partial data survives.
- State COLLECT:
  - For every i with done[i]=1, x_reg[i] and w_reg[i] load from x_in/w_in and fill_mask[i] is set.
  - A repeat done on an already-filled channel overwrites its data (latest wins) and is not an overrun.
  - Several done bits in one cycle are all captured.
  - If (fill_mask | done) is all ones at an edge, that edge moves the state to STREAM with counter=0. The first beat is valid in the next cycle, so latency is 1 cycle from the final capturing edge.
- State STREAM:
  - out_valid=1; out_x=x_reg[counter], out_w=w_reg[counter], out_idx=counter, out_last=(counter==N_CH-1). These are combinational from registers.
  - out_valid falling edge: out_x and out_w are forced to 0 whenever out_valid=0.
  - A beat transfers on out_valid & out_ready. On transfer, the counter increments, or on the last beat the state moves to WAIT_DONE and the counter clears.
  - With out_ready held high, one beat per cycle and N_CH consecutive cycles.
  - With out_ready low, the beat and its index hold stable.
- State WAIT_DONE: out_valid=0. On neuron_done, fill_mask clears and the state returns to COLLECT.
- neuron_done in COLLECT or STREAM is ignored.
- Overrun:
  - Any done bit in STREAM, or in WAIT_DONE without neuron_done in the same cycle, is discarded: storage and fill_mask are unchanged and overrun is set.
  - overrun clears only on reset.
- Simultaneous neuron_done and done in WAIT_DONE: done[i] is captured into the new round (fill_mask[i]=1 after the edge, data loaded), and overrun is not set.
- N_CH=1: out_idx is always 0, out_last is always 1 while valid, and a single done goes to STREAM.
- Arithmetic: the counter never exceeds N_CH-1; no wrap past N_CH-1. Data is passed through unmodified; no sign handling.

Test Plan:
- N_CH=3, DW=16: done=001 with x0=0x0011/w0=0x00A1, then 100 (0x0033/0x00C3), then 010 (0x0022/0x00B2); out_ready=1 -> fill_mask goes 001, 101, 111. Beats arrive in the 3 cycles after the final capture as idx 0,1,2 with x 0x0011, 0x0022, 0x0033, and out_last only on idx 2.
- Same fill, out_ready toggled 1,0,0,1,1 -> beat idx1 is held for 2 cycles with stable data; 3 transfers total; WAIT_DONE entered after idx2.
- done=111 in a single cycle -> all three captured; out_valid is high on the next cycle.
- done=010 during STREAM -> stream data unchanged and overrun=1. After neuron_done, fill_mask=000 and overrun stays 1 until reset.
- In WAIT_DONE, neuron_done=1 with done=001 (x0=0x0055) -> next cycle: COLLECT, fill_mask=001, x_reg0=0x0055, overrun=0.
- Reset asserted mid-STREAM at idx1 -> next cycle: out_valid=0, fill_mask=0, busy=0. A fresh 3-channel fill then streams from idx 0. Repeat the directed fill with N_CH=1 and N_CH=8 (DW=8).

Source files
------------

// File: rtl/operand_gather_buffer.sv
// operand_gather_buffer
//   Collects one (x, w) operand pair from each of N_CH upstream channels, each
//   on that channel's done strobe. When every channel has reported, the pairs
//   are streamed to the neuron MAC in channel order over valid/ready. The round
//   then stays locked until neuron_done, after which a new round is collected.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   done         per-channel capture strobe
//   x_in, w_in   packed operands, channel i at [i*DW +: DW]
//   out_x/out_w  current beat (zero when out_valid is low)
//   out_valid    beat valid
//   out_ready    MAC accepts the beat
//   out_idx      channel index of the current beat
//   out_last     current beat is channel N_CH-1
//   neuron_done  MAC finished; releases the round
//   fill_mask    channels captured in the current round
//   busy         state is not COLLECT
//   overrun      sticky: a done arrived while the round was locked
module operand_gather_buffer #(
  parameter int unsigned N_CH = 3,
  parameter int unsigned DW   = 16,
  localparam int unsigned IW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      done,
  input  logic [N_CH*DW-1:0]   x_in,
  input  logic [N_CH*DW-1:0]   w_in,
  output logic [DW-1:0]        out_x,
  output logic [DW-1:0]        out_w,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_idx,
  output logic                 out_last,
  input  logic                 neuron_done,
  output logic [N_CH-1:0]      fill_mask,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

  typedef enum logic [1:0] {
    S_COLLECT   = 2'd0,
    S_STREAM    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [N_CH-1:0][DW-1:0]    x_q, x_d;
  logic [N_CH-1:0][DW-1:0]    w_q, w_d;
  logic [N_CH-1:0]            fill_q, fill_d;
  logic [IW-1:0]              cnt_q, cnt_d;
  logic                       ovr_q, ovr_d;
  logic [N_CH-1:0]            cap;
  logic [DW-1:0]              sel_x, sel_w;

  // State and storage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_COLLECT;
      x_q     <= '0;
      w_q     <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, capture and overrun logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    x_d     = x_q;
    w_d     = w_q;
    ovr_d   = ovr_q;
    cap     = '0;

    case (state_q)
      S_COLLECT: begin
        // Repeat strobes on filled channels simply overwrite (latest wins)
        cap    = done;
        fill_d = fill_q | done;
        if (&(fill_q | done)) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end

      S_STREAM: begin
        if (|done) begin
          ovr_d = 1'b1;
        end
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d = S_WAIT_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end

      S_WAIT_DONE: begin
        // A strobe coinciding with the release belongs to the new round
        if (neuron_done) begin
          cap     = done;
          fill_d  = done;
          state_d = S_COLLECT;
        end else if (|done) begin
          ovr_d = 1'b1;
        end
      end

      default: begin
        state_d = S_COLLECT;
        cnt_d   = '0;
        fill_d  = '0;
      end
    endcase

    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cap[i]) begin
        x_d[i] = x_in[i*DW +: DW];
        w_d[i] = w_in[i*DW +: DW];
      end
    end
  end

  // Beat select by counter
  always_comb begin
    sel_x = '0;
    sel_w = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cnt_q == IW'(i)) begin
        sel_x = x_q[i];
        sel_w = w_q[i];
      end
    end
  end

  // Outputs decoded straight from registers; data is zeroed while not valid
  assign out_valid = (state_q == S_STREAM);
  assign out_x     = out_valid ? sel_x : '0;
  assign out_w     = out_valid ? sel_w : '0;
  assign out_idx   = cnt_q;
  assign out_last  = out_valid && (cnt_q == LAST_IDX);
  assign fill_mask = fill_q;
  assign busy      = (state_q != S_COLLECT);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_operand_gather_buffer.sv
// Self-checking bench for operand_gather_buffer: 3-channel table + directed
// corner sequences, plus 1-channel and 8-channel instances. Beat data is
// checked against per-instance scoreboard queues.
module tb_operand_gather_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 3-channel, DW=16 instance
  logic [2:0]  done3;
  logic [47:0] xin3, win3;
  logic [15:0] ox3, ow3;
  logic        ov3, rdy3, last3, nd3, busy3, ovr3;
  logic [1:0]  idx3;
  logic [2:0]  fill3;

  // 1-channel, DW=16 instance
  logic [0:0]  done1;
  logic [15:0] xin1, win1, ox1, ow1;
  logic        ov1, rdy1, last1, nd1, busy1, ovr1;
  logic [0:0]  idx1;
  logic [0:0]  fill1;

  // 8-channel, DW=8 instance
  logic [7:0]  done8;
  logic [63:0] xin8, win8;
  logic [7:0]  ox8, ow8;
  logic        ov8, rdy8, last8, nd8, busy8, ovr8;
  logic [2:0]  idx8;
  logic [7:0]  fill8;

  operand_gather_buffer #(.N_CH(3), .DW(16)) dut3 (
    .clk(clk), .reset(reset), .done(done3), .x_in(xin3), .w_in(win3),
    .out_x(ox3), .out_w(ow3), .out_valid(ov3), .out_ready(rdy3),
    .out_idx(idx3), .out_last(last3), .neuron_done(nd3),
    .fill_mask(fill3), .busy(busy3), .overrun(ovr3));

  operand_gather_buffer #(.N_CH(1), .DW(16)) dut1 (
    .clk(clk), .reset(reset), .done(done1), .x_in(xin1), .w_in(win1),
    .out_x(ox1), .out_w(ow1), .out_valid(ov1), .out_ready(rdy1),
    .out_idx(idx1), .out_last(last1), .neuron_done(nd1),
    .fill_mask(fill1), .busy(busy1), .overrun(ovr1));

  operand_gather_buffer #(.N_CH(8), .DW(8)) dut8 (
    .clk(clk), .reset(reset), .done(done8), .x_in(xin8), .w_in(win8),
    .out_x(ox8), .out_w(ow8), .out_valid(ov8), .out_ready(rdy8),
    .out_idx(idx8), .out_last(last8), .neuron_done(nd8),
    .fill_mask(fill8), .busy(busy8), .overrun(ovr8));

  typedef struct {
    int          idx;
    logic [15:0] x;
    logic [15:0] w;
    logic        last;
  } beat_t;

  beat_t sb3[$];
  beat_t sb1[$];
  beat_t sb8[$];
  beat_t e3, e1, e8;

  int    total = 0;
  int    bad   = 0;
  string ctx   = "init";

  localparam logic [47:0] X3 = {16'h0033, 16'h0022, 16'h0011};
  localparam logic [47:0] W3 = {16'h00C3, 16'h00B2, 16'h00A1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h expected %0h", ctx, nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push3(input logic [47:0] xv, input logic [47:0] wv);
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      b.idx  = i;
      b.x    = xv[i*16 +: 16];
      b.w    = wv[i*16 +: 16];
      b.last = (i == 2);
      sb3.push_back(b);
    end
  endtask

  task automatic chk3(input logic [2:0] f, input logic v, input logic [1:0] ix,
                      input logic l, input logic b, input logic o,
                      input logic [15:0] ex, input logic [15:0] ew);
    chk("fill_mask", 32'(fill3), 32'(f));
    chk("out_valid", 32'(ov3), 32'(v));
    chk("out_idx", 32'(idx3), 32'(ix));
    chk("out_last", 32'(last3), 32'(l));
    chk("busy", 32'(busy3), 32'(b));
    chk("overrun", 32'(ovr3), 32'(o));
    chk("out_x", 32'(ox3), 32'(ex));
    chk("out_w", 32'(ow3), 32'(ew));
  endtask

  // Scoreboard monitors: a beat transfers on valid & ready seen at the negedge
  always @(negedge clk) begin
    if (!reset && ov3 && rdy3) begin
      chk("sb3_expected", 32'(sb3.size() != 0), 32'd1);
      if (sb3.size() != 0) begin
        e3 = sb3.pop_front();
        chk("sb3_idx", 32'(idx3), 32'(e3.idx));
        chk("sb3_x", 32'(ox3), 32'(e3.x));
        chk("sb3_w", 32'(ow3), 32'(e3.w));
        chk("sb3_last", 32'(last3), 32'(e3.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ov1 && rdy1) begin
      chk("sb1_expected", 32'(sb1.size() != 0), 32'd1);
      if (sb1.size() != 0) begin
        e1 = sb1.pop_front();
        chk("sb1_idx", 32'(idx1), 32'(e1.idx));
        chk("sb1_x", 32'(ox1), 32'(e1.x));
        chk("sb1_w", 32'(ow1), 32'(e1.w));
        chk("sb1_last", 32'(last1), 32'(e1.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ov8 && rdy8) begin
      chk("sb8_expected", 32'(sb8.size() != 0), 32'd1);
      if (sb8.size() != 0) begin
        e8 = sb8.pop_front();
        chk("sb8_idx", 32'(idx8), 32'(e8.idx));
        chk("sb8_x", 32'(ox8), 32'(e8.x));
        chk("sb8_w", 32'(ow8), 32'(e8.w));
        chk("sb8_last", 32'(last8), 32'(e8.last));
      end
    end
  end

  typedef struct {
    logic [2:0]  d;
    logic        rdy;
    logic        nd;
    logic [2:0]  fill;
    logic        v;
    logic [1:0]  idx;
    logic        last;
    logic        busy;
    logic        ovr;
    logic [15:0] ex;
    logic [15:0] ew;
    logic        push;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] d, input logic rdy, input logic nd,
                              input logic [2:0] fill, input logic v, input logic [1:0] idx,
                              input logic last, input logic busy, input logic ovr,
                              input logic [15:0] ex, input logic [15:0] ew, input logic push);
    vec_t r;
    r.d = d; r.rdy = rdy; r.nd = nd; r.fill = fill; r.v = v; r.idx = idx;
    r.last = last; r.busy = busy; r.ovr = ovr; r.ex = ex; r.ew = ew; r.push = push;
    return r;
  endfunction

  vec_t       tbl [14];
  logic [7:0] seq8 [7];
  logic [7:0] m8x [8];
  logic [7:0] m8w [8];
  logic [7:0] acc;
  logic [47:0] xv;
  logic [47:0] wv;
  beat_t      b;

  initial begin
    reset = 1'b1;
    done3 = '0; xin3 = X3; win3 = W3; rdy3 = 1'b0; nd3 = 1'b0;
    done1 = '0; xin1 = '0; win1 = '0; rdy1 = 1'b0; nd1 = 1'b0;
    done8 = '0; xin8 = '0; win8 = '0; rdy8 = 1'b0; nd8 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      m8x[c] = '0;
      m8w[c] = '0;
    end

    // Table: {done, ready, neuron_done} -> state after the edge
    tbl[0]  = mk(3'b001, 1, 1, 3'b001, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    tbl[1]  = mk(3'b100, 1, 0, 3'b101, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    tbl[2]  = mk(3'b010, 1, 0, 3'b111, 1, 0, 0, 1, 0, 16'h0011, 16'h00A1, 1);
    tbl[3]  = mk(3'b000, 1, 1, 3'b111, 1, 1, 0, 1, 0, 16'h0022, 16'h00B2, 0);
    tbl[4]  = mk(3'b000, 1, 0, 3'b111, 1, 2, 1, 1, 0, 16'h0033, 16'h00C3, 0);
    tbl[5]  = mk(3'b000, 1, 0, 3'b111, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0);
    tbl[6]  = mk(3'b000, 0, 1, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    tbl[7]  = mk(3'b111, 1, 0, 3'b111, 1, 0, 0, 1, 0, 16'h0011, 16'h00A1, 1);
    tbl[8]  = mk(3'b000, 1, 0, 3'b111, 1, 1, 0, 1, 0, 16'h0022, 16'h00B2, 0);
    tbl[9]  = mk(3'b000, 0, 0, 3'b111, 1, 1, 0, 1, 0, 16'h0022, 16'h00B2, 0);
    tbl[10] = mk(3'b000, 0, 0, 3'b111, 1, 1, 0, 1, 0, 16'h0022, 16'h00B2, 0);
    tbl[11] = mk(3'b000, 1, 0, 3'b111, 1, 2, 1, 1, 0, 16'h0033, 16'h00C3, 0);
    tbl[12] = mk(3'b000, 1, 0, 3'b111, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0);
    tbl[13] = mk(3'b000, 0, 1, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);

    // Reset state
    tick();
    tick();
    ctx = "reset";
    chk3(3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    chk("n1_valid", 32'(ov1), 32'd0);
    chk("n8_fill", 32'(fill8), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      ctx = $sformatf("tbl%0d", i);
      done3 = tbl[i].d;
      rdy3  = tbl[i].rdy;
      nd3   = tbl[i].nd;
      if (tbl[i].push) push3(X3, W3);
      tick();
      chk3(tbl[i].fill, tbl[i].v, tbl[i].idx, tbl[i].last, tbl[i].busy,
           tbl[i].ovr, tbl[i].ex, tbl[i].ew);
    end
    chk("sb3_drained_tbl", 32'(sb3.size()), 32'd0);

    // neuron_done and done together in WAIT_DONE start the next round
    ctx = "wait_simul";
    done3 = 3'b111; rdy3 = 1'b1; nd3 = 1'b0;
    push3(X3, W3);
    tick();
    done3 = '0;
    repeat (3) tick();
    chk("valid_wait", 32'(ov3), 32'd0);
    chk("busy_wait", 32'(busy3), 32'd1);
    xv = X3; wv = W3;
    xv[15:0] = 16'h0055; wv[15:0] = 16'h00A5;
    xin3 = xv; win3 = wv; done3 = 3'b001; nd3 = 1'b1; rdy3 = 1'b0;
    tick();
    chk("fill_new", 32'(fill3), 32'h1);
    chk("busy_new", 32'(busy3), 32'd0);
    chk("ovr_new", 32'(ovr3), 32'd0);
    xin3 = X3; win3 = W3; done3 = 3'b110; nd3 = 1'b0; rdy3 = 1'b1;
    push3(xv, wv);
    tick();
    done3 = '0;
    chk("x0_kept", 32'(ox3), 32'h0055);
    repeat (3) tick();
    nd3 = 1'b1; rdy3 = 1'b0;
    tick();
    nd3 = 1'b0;
    chk("fill_clear", 32'(fill3), 32'd0);

    // done during STREAM is dropped and flags overrun
    ctx = "ovr_stream";
    done3 = 3'b111;
    push3(X3, W3);
    tick();
    xv = X3; xv[31:16] = 16'hDEAD;
    xin3 = xv; done3 = 3'b010;
    tick();
    chk3(3'b111, 1, 0, 0, 1, 1, 16'h0011, 16'h00A1);
    xin3 = X3; done3 = '0; rdy3 = 1'b1;
    repeat (3) tick();
    chk("valid_end", 32'(ov3), 32'd0);
    rdy3 = 1'b0; nd3 = 1'b1;
    tick();
    nd3 = 1'b0;
    chk("fill_after", 32'(fill3), 32'd0);
    chk("ovr_sticky", 32'(ovr3), 32'd1);
    repeat (2) tick();
    chk("ovr_sticky2", 32'(ovr3), 32'd1);

    // Reset mid-STREAM at idx1 aborts the round
    ctx = "reset_mid";
    done3 = 3'b111; rdy3 = 1'b1;
    push3(X3, W3);
    tick();
    done3 = '0;
    tick();
    chk("idx_before", 32'(idx3), 32'd1);
    rdy3 = 1'b0; reset = 1'b1;
    sb3.delete();
    tick();
    reset = 1'b0;
    chk3(3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    done3 = 3'b111;
    push3(X3, W3);
    tick();
    done3 = '0;
    chk("restart_idx", 32'(idx3), 32'd0);
    chk("restart_x", 32'(ox3), 32'h0011);
    rdy3 = 1'b1;
    repeat (3) tick();
    rdy3 = 1'b0;
    chk("valid_wait2", 32'(ov3), 32'd0);

    // done in WAIT_DONE without neuron_done is an overrun
    ctx = "ovr_wait";
    done3 = 3'b010;
    tick();
    done3 = '0;
    chk("ovr_w", 32'(ovr3), 32'd1);
    chk("fill_w", 32'(fill3), 32'h7);
    nd3 = 1'b1;
    tick();
    nd3 = 1'b0;
    chk("fill_w_clr", 32'(fill3), 32'd0);
    chk("busy_w_clr", 32'(busy3), 32'd0);

    // Single-channel instance
    ctx = "n1";
    done1 = 1'b1; xin1 = 16'hBEEF; win1 = 16'h1234; rdy1 = 1'b0;
    b.idx = 0; b.x = 16'hBEEF; b.w = 16'h1234; b.last = 1'b1;
    sb1.push_back(b);
    tick();
    done1 = '0;
    chk("valid", 32'(ov1), 32'd1);
    chk("idx", 32'(idx1), 32'd0);
    chk("last", 32'(last1), 32'd1);
    chk("fill", 32'(fill1), 32'd1);
    tick();
    chk("hold_x", 32'(ox1), 32'hBEEF);
    chk("hold_last", 32'(last1), 32'd1);
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    chk("valid_end", 32'(ov1), 32'd0);
    chk("last_end", 32'(last1), 32'd0);
    chk("x_zero", 32'(ox1), 32'd0);
    nd1 = 1'b1;
    tick();
    nd1 = 1'b0;
    chk("busy_end", 32'(busy1), 32'd0);
    chk("fill_end", 32'(fill1), 32'd0);

    // Eight-channel instance, out-of-order fill with a repeat on channel 0
    ctx = "n8";
    seq8 = '{8'h01, 8'h80, 8'h01, 8'h08, 8'h06, 8'h30, 8'h40};
    acc = '0;
    rdy8 = 1'b1;
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 8; c++) begin
        xin8[c*8 +: 8] = 8'($urandom);
        win8[c*8 +: 8] = 8'($urandom);
        if (seq8[s][c]) begin
          m8x[c] = xin8[c*8 +: 8];
          m8w[c] = win8[c*8 +: 8];
        end
      end
      done8 = seq8[s];
      acc = acc | seq8[s];
      if (acc == 8'hFF) begin
        for (int c = 0; c < 8; c++) begin
          b.idx = c; b.x = 16'(m8x[c]); b.w = 16'(m8w[c]); b.last = (c == 7);
          sb8.push_back(b);
        end
      end
      tick();
      chk("fill", 32'(fill8), 32'(acc));
      chk("valid", 32'(ov8), 32'(acc == 8'hFF));
    end
    done8 = '0;
    repeat (8) tick();
    rdy8 = 1'b0;
    chk("valid_end", 32'(ov8), 32'd0);
    chk("busy_end", 32'(busy8), 32'd1);
    chk("ovr", 32'(ovr8), 32'd0);
    nd8 = 1'b1;
    tick();
    nd8 = 1'b0;
    chk("fill_end", 32'(fill8), 32'd0);

    ctx = "final";
    chk("sb3_empty", 32'(sb3.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);
    chk("sb8_empty", 32'(sb8.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
